// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues single-outstanding imem fetches and hands words to decode.
// Optional macro BRANCH_MISALIGN_CHECK_EN flags misaligned redirect targets instead of forcing word alignment.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        NextPCSrc,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef BRANCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign,
  output logic [31:0] misalign_addr
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;

  logic        redirect_req;
  logic        redirect;
  logic [31:0] load_target;
  logic [31:0] pc_inc;
  logic        handshake;

  assign redirect_req = br_valid & NextPCSrc;
  assign pc_inc       = pc_q + PC_STEP;

`ifdef BRANCH_MISALIGN_CHECK_EN
  logic        misaligned;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  // A misaligned target is reported and otherwise behaves as if no redirect happened.
  assign misaligned  = (br_target[1:0] != 2'b00);
  assign redirect    = redirect_req & ~misaligned;
  assign load_target = br_target;

  always_comb begin
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (redirect_req && misaligned) begin
      misalign_d      = 1'b1;
      misalign_addr_d = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0000_0000;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign redirect    = redirect_req;
  assign load_target = br_target & 32'hFFFF_FFFC;
`endif

  // The redirect mask on if_valid guarantees no handshake completes in a redirect cycle.
  assign if_valid  = hold_q & ~redirect;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign handshake = if_valid & id_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    hold_d   = hold_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (redirect) pc_d = load_target;
      end

      S_FETCH: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          // A redirect coinciding with the grant makes the accepted request stale.
          if (redirect) begin
            pc_d   = load_target;
            kill_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end else if (redirect) begin
          pc_d = load_target;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d   = load_target;
          kill_d = 1'b1;
        end
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = req_pc_q;
            hold_d  = 1'b1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = load_target;
          hold_d  = 1'b0;
          state_d = S_FETCH;
        end else if (handshake) begin
          hold_d  = 1'b0;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      kill_q   <= 1'b0;
      hold_q   <= 1'b0;
      instr_q  <= NOP_INSTR;
      ifpc_q   <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      hold_q   <= hold_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a transaction-level model predicts fetch addresses and delivered words.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic        NextPCSrc = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
`ifdef BRANCH_MISALIGN_CHECK_EN
  logic        misalign;
  logic [31:0] misalign_addr;
`endif

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_valid   (br_valid),
    .NextPCSrc  (NextPCSrc),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready)
`ifdef BRANCH_MISALIGN_CHECK_EN
    ,
    .misalign     (misalign),
    .misalign_addr(misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // Memory side state used by the stimulus driver.
  bit          mem_pending = 1'b0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = 32'h0;

  // Reference model state.
  bit          m_booted = 1'b0;
  bit          m_inflight = 1'b0;
  bit          m_inf_killed = 1'b0;
  bit          m_held = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inf_pc = 32'h0;
  bit          m_mis = 1'b0;
  logic [31:0] m_mis_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(5))
      0: return 32'h0000_0100;
      1: return 32'h0000_0200;
      2: return 32'hFFFF_FFFC;
      3: return 32'h0000_0102;
      4: return $urandom() & 32'hFFFF_FFFC;
      default: return $urandom();
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int ncycles, input int gnt_pct, input int max_lat,
                               input int ready_pct, input int redir_pct, input int spur_pct);
    bit          fire;
    bit          rsp;
    logic [31:0] addr_s;
    for (int i = 0; i < ncycles; i++) begin
      @(negedge clk);
      fire   = rst_n & imem_req & imem_gnt;
      addr_s = imem_addr;
      rsp    = imem_rvalid & mem_pending;
      @(posedge clk);
      #1;
      if (rsp) mem_pending = 1'b0;
      if (fire) begin
        mem_pending = 1'b1;
        mem_addr    = addr_s;
        mem_lat     = int'($urandom_range(max_lat));
      end
      if (mem_pending) begin
        if (mem_lat == 0) imem_rvalid = 1'b1;
        else begin
          imem_rvalid = 1'b0;
          mem_lat--;
        end
      end else begin
        imem_rvalid = (int'($urandom_range(99)) < spur_pct);
      end
      imem_rdata = (imem_rvalid && mem_pending) ? mem_word(mem_addr) : $urandom();
      imem_gnt   = (int'($urandom_range(99)) < gnt_pct);
      id_ready   = (int'($urandom_range(99)) < ready_pct);
      br_valid   = (int'($urandom_range(99)) < redir_pct);
      NextPCSrc  = br_valid ? ($urandom_range(3) != 0) : $urandom_range(1) != 0;
      br_target  = pick_target();
    end
  endtask

  // Model: at each falling edge predict what the coming rising edge does.
  always @(negedge clk) begin : model
    logic        redir;
    logic        mis;
    logic [31:0] tgt;
    if (!rst_n) begin
      checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
      checkOutput("rst_imem_addr", imem_addr, 32'h0);
      checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
      checkOutput("rst_if_instr", if_instr, 32'h0000_0013);
      checkOutput("rst_if_pc", if_pc, 32'h0);
`ifdef BRANCH_MISALIGN_CHECK_EN
      checkOutput("rst_misalign", {31'b0, misalign}, 32'h0);
      checkOutput("rst_misalign_addr", misalign_addr, 32'h0);
`endif
      m_booted = 0; m_inflight = 0; m_inf_killed = 0; m_held = 0;
      m_pc = 32'h0; m_mis = 0; m_mis_addr = 32'h0;
      exp_q.delete();
    end else begin
      redir = br_valid & NextPCSrc;
      mis   = 1'b0;
`ifdef BRANCH_MISALIGN_CHECK_EN
      tgt = br_target;
      if (redir && br_target[1:0] != 2'b00) begin
        redir = 1'b0;
        mis   = 1'b1;
      end
      checkOutput("misalign", {31'b0, misalign}, {31'b0, m_mis});
      checkOutput("misalign_addr", misalign_addr, m_mis_addr);
      m_mis = mis;
      if (mis) m_mis_addr = br_target;
`else
      tgt = {br_target[31:2], 2'b00};
`endif
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_booted && !m_inflight && !m_held});
      checkOutput("if_valid", {31'b0, if_valid}, {31'b0, m_held && !redir});
      if (!m_booted) begin
        m_booted = 1;
        if (redir) m_pc = tgt;
      end else if (m_held) begin
        if (redir) begin
          m_held = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_pc = tgt;
        end else if (id_ready) begin
          m_held = 0;
        end
      end else if (m_inflight) begin
        if (redir) begin
          m_inf_killed = 1;
          m_pc = tgt;
        end
        if (imem_rvalid) begin
          m_inflight = 0;
          if (!m_inf_killed) begin
            m_held = 1;
            exp_q.push_back('{pc: m_inf_pc, instr: mem_word(m_inf_pc)});
          end
        end
      end else begin
        checkOutput("imem_addr", imem_addr, m_pc);
        if (imem_gnt) begin
          m_inflight   = 1;
          m_inf_pc     = m_pc;
          m_inf_killed = redir;
          m_pc         = redir ? tgt : m_pc + 32'd4;
        end else if (redir) begin
          m_pc = tgt;
        end
      end
    end
  end

  // Monitor: whenever decode is offered a word, compare it against the scoreboard head.
  always @(negedge clk) begin : monitor
    if (rst_n && if_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_if_valid: got if_pc %h with empty scoreboard at %0t", if_pc, $time);
      end else begin
        checkOutput("if_pc", if_pc, exp_q[0].pc);
        checkOutput("if_instr", if_instr, exp_q[0].instr);
        if (id_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(20, 100, 0, 100, 0, 0);
    applyStimulus(40, 100, 0, 15, 0, 0);
    applyStimulus(1500, 70, 3, 70, 10, 5);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    mem_pending = 1'b0;
    imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1500, 50, 2, 50, 25, 10);
    applyStimulus(300, 100, 0, 100, 40, 0);
    applyStimulus(300, 100, 0, 30, 5, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
